// File: rtl/mdu_pkg.sv
// Shared encodings for the E-stage multiply/divide unit; the controller's
// decoder imports the same op codes so both sides agree on the field layout.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int MDU_MULT_CYC = 5;
  localparam int MDU_DIV_CYC  = 10;

  function automatic int mdu_max(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  function automatic logic is_mul(input mdu_op_e o);
    return (o == MDU_MULT) || (o == MDU_MULTU);
  endfunction

  function automatic logic is_div(input mdu_op_e o);
    return (o == MDU_DIV) || (o == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit with private HI/LO. The result is formed
// combinationally from operands latched at start and written only at commit.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYC = MDU_MULT_CYC,
  parameter int DIV_CYC  = MDU_DIV_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYC = mdu_max(MULT_CYC, DIV_CYC);
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC - 1);

  mdu_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]     a_q;
  logic [31:0]     b_q;
  mdu_op_e         op_q;
  mdu_op_e         op_in;

  logic            res_we;
  logic [31:0]     res_hi;
  logic [31:0]     res_lo;
  logic [63:0]     smul;
  logic [63:0]     umul;
  logic [31:0]     div_b;
  logic signed [31:0] squo;
  logic signed [31:0] srem;
  logic [31:0]     uquo;
  logic [31:0]     urem;

  // Code 7 is reserved and behaves exactly like NONE.
  always_comb begin
    case (op)
      3'd1:    op_in = MDU_MULT;
      3'd2:    op_in = MDU_MULTU;
      3'd3:    op_in = MDU_DIV;
      3'd4:    op_in = MDU_DIVU;
      3'd5:    op_in = MDU_MTHI;
      3'd6:    op_in = MDU_MTLO;
      default: op_in = MDU_NONE;
    endcase
  end

  assign smul  = 64'($signed(a_q)) * 64'($signed(b_q));
  assign umul  = {32'd0, a_q} * {32'd0, b_q};
  // A zero divisor is replaced so the dividers never see it; the commit is
  // suppressed for that case anyway.
  assign div_b = (b_q == 32'd0) ? 32'd1 : b_q;
  assign squo  = $signed(a_q) / $signed(div_b);
  assign srem  = $signed(a_q) % $signed(div_b);
  assign uquo  = a_q / div_b;
  assign urem  = a_q % div_b;

  always_comb begin
    res_we = 1'b0;
    res_hi = HI;
    res_lo = LO;
    case (op_q)
      MDU_MULT: begin
        res_we = 1'b1;
        res_hi = smul[63:32];
        res_lo = smul[31:0];
      end
      MDU_MULTU: begin
        res_we = 1'b1;
        res_hi = umul[63:32];
        res_lo = umul[31:0];
      end
      MDU_DIV: begin
        if (b_q != 32'd0) begin
          res_we = 1'b1;
          // Most-negative / -1 overflows the quotient; pin it explicitly.
          if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
            res_hi = 32'd0;
            res_lo = 32'h8000_0000;
          end else begin
            res_hi = srem;
            res_lo = squo;
          end
        end
      end
      MDU_DIVU: begin
        if (b_q != 32'd0) begin
          res_we = 1'b1;
          res_hi = urem;
          res_lo = uquo;
        end
      end
      default: begin
        res_we = 1'b0;
      end
    endcase
  end

  assign busy = (state == ST_RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= MDU_NONE;
      HI    <= '0;
      LO    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (is_mul(op_in)) begin
              a_q   <= A;
              b_q   <= B;
              op_q  <= op_in;
              cnt   <= MULT_LOAD;
              state <= ST_RUN;
            end else if (is_div(op_in)) begin
              a_q   <= A;
              b_q   <= B;
              op_q  <= op_in;
              cnt   <= DIV_LOAD;
              state <= ST_RUN;
            end else if (op_in == MDU_MTHI) begin
              HI <= A;
            end else if (op_in == MDU_MTLO) begin
              LO <= A;
            end
          end
        end
        ST_RUN: begin
          // Starts arriving here are dropped; the hazard unit owns that stall.
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (res_we) begin
              HI <= res_hi;
              LO <= res_lo;
            end
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: hand-computed HI/LO values and busy-window lengths.
module tb_e_mdu;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_errors = 0;

  e_mdu dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one start pulse; returns right after the sampling edge (+1).
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'd0;
  endtask

  // Count edges while busy, bounded.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cyc,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    issue(o, a, b);
    wait_idle(cyc);
    check({tag, "_busy_cycles"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_hi"}, 64'(HI), 64'(exp_hi));
    check({tag, "_lo"}, 64'(LO), 64'(exp_lo));
  endtask

  initial begin
    int cyc;
    reset = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    A     = '0;
    B     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // 1. reset mid-operation clears state asynchronously
    run_op("pre_mthi", 3'd5, 32'h55, 32'd0, 0, 32'h55, 32'h0);
    run_op("pre_mtlo", 3'd6, 32'h66, 32'd0, 0, 32'h55, 32'h66);
    issue(3'd1, 32'd9, 32'd9);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_hi", 64'(HI), 64'd0);
    check("async_rst_lo", 64'(LO), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op("mult_3x4", 3'd1, 32'd3, 32'd4, 5, 32'd0, 32'd12);

    // 2. multiply
    run_op("mult_neg1x2", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu_ffx2", 3'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);

    // 3. divide
    run_op("div_m7_2", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_m2", 3'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);
    run_op("divu_7_2", 3'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);

    // 4. boundaries
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
    run_op("set_hi", 3'd5, 32'h11, 32'd0, 0, 32'h11, 32'h8000_0000);
    run_op("set_lo", 3'd6, 32'h22, 32'd0, 0, 32'h11, 32'h22);
    run_op("div_by0", 3'd3, 32'd5, 32'd0, 10, 32'h11, 32'h22);
    run_op("divu_by0", 3'd4, 32'd5, 32'd0, 10, 32'h11, 32'h22);
    run_op("op7_none", 3'd7, 32'h99, 32'd0, 0, 32'h11, 32'h22);

    // 5. starts while busy are ignored; operand changes have no effect
    issue(3'd1, 32'd6, 32'd7);
    @(negedge clk);
    start = 1'b1;
    op    = 3'd5;
    A     = 32'hDEAD;
    B     = 32'hBEEF;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'd0;
    A     = 32'h1234_5678;
    B     = 32'h0000_0100;
    check("ign_hi_hold", 64'(HI), 64'h11);
    check("ign_lo_hold", 64'(LO), 64'h22);
    wait_idle(cyc);
    check("ign_busy_cycles", 64'(cyc), 64'd4);
    check("ign_hi", 64'(HI), 64'd0);
    check("ign_lo", 64'(LO), 64'd42);

    // 6. mt* from idle, and mtlo immediately after a commit
    run_op("mthi_1234", 3'd5, 32'h1234, 32'd0, 0, 32'h1234, 32'd42);
    run_op("divu_100_7", 3'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);
    run_op("mtlo_after", 3'd6, 32'hCAFE, 32'd0, 0, 32'd2, 32'hCAFE);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
